// File: rtl/nibble_pkg.sv
// Shared opcode, ALU-select and FSM encodings for the nibble sequencer.
// Define NIBBLE_SEQ_STEP_EN to add the single-step input on the top.
package nibble_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        OP_JC    = 4'h0,
        OP_JNC   = 4'h1,
        OP_CMPI  = 4'h2,
        OP_CMPM  = 4'h3,
        OP_LIT   = 4'h4,
        OP_IN    = 4'h5,
        OP_LD    = 4'h6,
        OP_ST    = 4'h7,
        OP_JZ    = 4'h8,
        OP_JNZ   = 4'h9,
        OP_ADDI  = 4'hA,
        OP_ADDM  = 4'hB,
        OP_JMP   = 4'hC,
        OP_OUT   = 4'hD,
        OP_NANDI = 4'hE,
        OP_NANDM = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_PASS_A = 3'd0,
        ALU_PASS_B = 3'd1,
        ALU_ADD    = 3'd2,
        ALU_SUB    = 3'd3,
        ALU_NAND   = 3'd4
    } alu_sel_e;

    typedef struct packed {
        logic     fetch_en;
        logic     pc_inc;
        logic     pc_load;
        logic     oprnd_oe;
        logic     in_oe;
        logic     ram_oe;
        logic     alu_oe;
        logic     accu_we;
        logic     ram_we;
        logic     out_we;
        alu_sel_e alu_sel;
        logic     upd_c;
        logic     upd_z;
    } ctrl_t;

    localparam int CTRL_W = 15;
    localparam ctrl_t CTRL_IDLE = ctrl_t'(15'd0);

    // Branch condition evaluated against the registered flags.
    function automatic logic jump_taken(input opcode_e op, input logic c, input logic z);
        logic taken;
        case (op)
            OP_JC:   taken = c;
            OP_JNC:  taken = ~c;
            OP_JZ:   taken = z;
            OP_JNZ:  taken = ~z;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/nibble_sequencer_if.sv
// Control bus between the nibble sequencer (master) and its datapath (slave).
interface nibble_sequencer_if;
    import nibble_pkg::*;

    logic       enable;
    logic [3:0] instr;
    logic       alu_c;
    logic       alu_z;

    logic       phase;
    logic       c_flag;
    logic       z_flag;
    logic       fetch_en;
    logic       pc_inc;
    logic       pc_load;
    logic       oprnd_oe;
    logic       in_oe;
    logic       ram_oe;
    logic       alu_oe;
    logic       accu_we;
    logic       ram_we;
    logic       out_we;
    alu_sel_e   alu_sel;

    modport master (
        input  enable, instr, alu_c, alu_z,
        output phase, c_flag, z_flag,
        output fetch_en, pc_inc, pc_load,
        output oprnd_oe, in_oe, ram_oe, alu_oe,
        output accu_we, ram_we, out_we, alu_sel
    );

    modport slave (
        output enable, instr, alu_c, alu_z,
        input  phase, c_flag, z_flag,
        input  fetch_en, pc_inc, pc_load,
        input  oprnd_oe, in_oe, ram_oe, alu_oe,
        input  accu_we, ram_we, out_we, alu_sel
    );

endinterface

// File: rtl/nibble_sequencer_decode.sv
// Combinational control-word decode: state, opcode and flags to strobes.
// kill_i forces an all-zero word so a reset cycle never issues a write.
module nibble_decode
    import nibble_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] instr_i,
    input  logic       c_flag_i,
    input  logic       z_flag_i,
    input  logic       run_i,
    input  logic       kill_i,
    output ctrl_t      ctrl_o
);

    opcode_e op_s;
    assign op_s = opcode_e'(instr_i);

    // Control word; at most one bus driver is ever selected per opcode.
    always_comb begin
        ctrl_o = CTRL_IDLE;
        if (kill_i) begin
            ctrl_o = CTRL_IDLE;
        end else if (state_i == ST_FETCH) begin
            if (run_i) begin
                ctrl_o.fetch_en = 1'b1;
                ctrl_o.pc_inc   = 1'b1;
            end else begin
                ctrl_o = CTRL_IDLE;
            end
        end else begin
            case (op_s)
                OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP: begin
                    ctrl_o.pc_load = jump_taken(op_s, c_flag_i, z_flag_i);
                end
                OP_CMPI: begin
                    ctrl_o.oprnd_oe = 1'b1;
                    ctrl_o.alu_sel  = ALU_SUB;
                    ctrl_o.upd_c    = 1'b1;
                    ctrl_o.upd_z    = 1'b1;
                end
                OP_CMPM: begin
                    ctrl_o.ram_oe  = 1'b1;
                    ctrl_o.alu_sel = ALU_SUB;
                    ctrl_o.upd_c   = 1'b1;
                    ctrl_o.upd_z   = 1'b1;
                end
                OP_LIT: begin
                    ctrl_o.oprnd_oe = 1'b1;
                    ctrl_o.accu_we  = 1'b1;
                    ctrl_o.alu_sel  = ALU_PASS_B;
                end
                OP_IN: begin
                    ctrl_o.in_oe   = 1'b1;
                    ctrl_o.accu_we = 1'b1;
                    ctrl_o.alu_sel = ALU_PASS_B;
                end
                OP_LD: begin
                    ctrl_o.ram_oe  = 1'b1;
                    ctrl_o.accu_we = 1'b1;
                    ctrl_o.alu_sel = ALU_PASS_B;
                end
                OP_ST: begin
                    ctrl_o.alu_oe  = 1'b1;
                    ctrl_o.ram_we  = 1'b1;
                    ctrl_o.alu_sel = ALU_PASS_A;
                end
                OP_ADDI: begin
                    ctrl_o.oprnd_oe = 1'b1;
                    ctrl_o.accu_we  = 1'b1;
                    ctrl_o.alu_sel  = ALU_ADD;
                    ctrl_o.upd_c    = 1'b1;
                    ctrl_o.upd_z    = 1'b1;
                end
                OP_ADDM: begin
                    ctrl_o.ram_oe  = 1'b1;
                    ctrl_o.accu_we = 1'b1;
                    ctrl_o.alu_sel = ALU_ADD;
                    ctrl_o.upd_c   = 1'b1;
                    ctrl_o.upd_z   = 1'b1;
                end
                OP_OUT: begin
                    ctrl_o.alu_oe  = 1'b1;
                    ctrl_o.out_we  = 1'b1;
                    ctrl_o.alu_sel = ALU_PASS_A;
                end
                OP_NANDI: begin
                    ctrl_o.oprnd_oe = 1'b1;
                    ctrl_o.accu_we  = 1'b1;
                    ctrl_o.alu_sel  = ALU_NAND;
                    ctrl_o.upd_z    = 1'b1;
                end
                OP_NANDM: begin
                    ctrl_o.ram_oe  = 1'b1;
                    ctrl_o.accu_we = 1'b1;
                    ctrl_o.alu_sel = ALU_NAND;
                    ctrl_o.upd_z   = 1'b1;
                end
                default: begin
                    ctrl_o = CTRL_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/nibble_sequencer.sv
// Two-phase FETCH/EXEC sequencer with carry/zero flag registers.
// NIBBLE_SEQ_STEP_EN adds a step input that gates FETCH together with enable.
module nibble_sequencer
    import nibble_pkg::*;
(
    input  logic clock,
    input  logic reset,
`ifdef NIBBLE_SEQ_STEP_EN
    input  logic step,
`endif
    nibble_sequencer_if.master bus
);

    state_e state_q;
    state_e state_d;
    logic   c_flag_q;
    logic   z_flag_q;
    logic   run_s;
    ctrl_t  ctrl_s;

`ifdef NIBBLE_SEQ_STEP_EN
    assign run_s = bus.enable & step;
`else
    assign run_s = bus.enable;
`endif

    nibble_decode u_decode (
        .state_i  (state_q),
        .instr_i  (bus.instr),
        .c_flag_i (c_flag_q),
        .z_flag_i (z_flag_q),
        .run_i    (run_s),
        .kill_i   (reset),
        .ctrl_o   (ctrl_s)
    );

    // Next-state: EXEC always returns to FETCH after a single cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (run_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // State and flag registers; flags capture the ALU only when decode asks.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            c_flag_q <= 1'b0;
            z_flag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ctrl_s.upd_c) begin
                c_flag_q <= bus.alu_c;
            end else begin
                c_flag_q <= c_flag_q;
            end
            if (ctrl_s.upd_z) begin
                z_flag_q <= bus.alu_z;
            end else begin
                z_flag_q <= z_flag_q;
            end
        end
    end

    assign bus.phase    = (state_q == ST_EXEC);
    assign bus.c_flag   = c_flag_q;
    assign bus.z_flag   = z_flag_q;
    assign bus.fetch_en = ctrl_s.fetch_en;
    assign bus.pc_inc   = ctrl_s.pc_inc;
    assign bus.pc_load  = ctrl_s.pc_load;
    assign bus.oprnd_oe = ctrl_s.oprnd_oe;
    assign bus.in_oe    = ctrl_s.in_oe;
    assign bus.ram_oe   = ctrl_s.ram_oe;
    assign bus.alu_oe   = ctrl_s.alu_oe;
    assign bus.accu_we  = ctrl_s.accu_we;
    assign bus.ram_we   = ctrl_s.ram_we;
    assign bus.out_we   = ctrl_s.out_we;
    assign bus.alu_sel  = ctrl_s.alu_sel;

endmodule

// File: tb/tb_nibble_sequencer.sv
// Table-driven scoreboard bench for nibble_sequencer, plus multi-cycle sequences.
module tb_nibble_sequencer;
    import nibble_pkg::*;

    logic clock;
    logic reset;
`ifdef NIBBLE_SEQ_STEP_EN
    logic step;
`endif

    nibble_sequencer_if bus_if ();

    nibble_sequencer dut (
        .clock (clock),
        .reset (reset),
`ifdef NIBBLE_SEQ_STEP_EN
        .step  (step),
`endif
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe bit positions: fetch_en pc_inc pc_load oprnd in ram alu accu_we ram_we out_we
    localparam logic [9:0] S_NONE  = 10'b00_0000_0000;
    localparam logic [9:0] S_FETCH = 10'b11_0000_0000;
    localparam logic [9:0] S_PCL   = 10'b00_1000_0000;
    localparam logic [9:0] S_OPR   = 10'b00_0100_0000;
    localparam logic [9:0] S_IN    = 10'b00_0010_0000;
    localparam logic [9:0] S_RAM   = 10'b00_0001_0000;
    localparam logic [9:0] S_ALU   = 10'b00_0000_1000;
    localparam logic [9:0] S_ACC   = 10'b00_0000_0100;
    localparam logic [9:0] S_RAMW  = 10'b00_0000_0010;
    localparam logic [9:0] S_OUTW  = 10'b00_0000_0001;
    localparam logic [2:0] PA   = 3'd0;
    localparam logic [2:0] PB   = 3'd1;
    localparam logic [2:0] ADD  = 3'd2;
    localparam logic [2:0] SUB  = 3'd3;
    localparam logic [2:0] NAND = 3'd4;

    typedef struct {
        logic        rst;
        logic        en;
        logic [3:0]  instr;
        logic        ac;
        logic        az;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [15:0] act_word();
        return {bus_if.phase, bus_if.c_flag, bus_if.z_flag,
                bus_if.fetch_en, bus_if.pc_inc, bus_if.pc_load,
                bus_if.oprnd_oe, bus_if.in_oe, bus_if.ram_oe, bus_if.alu_oe,
                bus_if.accu_we, bus_if.ram_we, bus_if.out_we, 3'(bus_if.alu_sel)};
    endfunction

    task automatic add(input logic rst, input logic en, input logic [3:0] instr,
                       input logic ac, input logic az, input logic ph, input logic c,
                       input logic z, input logic [9:0] strb, input logic [2:0] sel);
        vec_t v;
        v.rst = rst; v.en = en; v.instr = instr; v.ac = ac; v.az = az;
        v.exp = {ph, c, z, strb, sel};
        vecs.push_back(v);
    endtask

    task automatic fet(input logic en, input logic c, input logic z);
        add(1'b0, en, 4'h0, 1'b0, 1'b0, 1'b0, c, z, en ? S_FETCH : S_NONE, PA);
    endtask

    task automatic ex(input logic en, input logic [3:0] instr, input logic ac, input logic az,
                      input logic c, input logic z, input logic [9:0] strb, input logic [2:0] sel);
        add(1'b0, en, instr, ac, az, 1'b1, c, z, strb, sel);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic en, input logic [3:0] instr,
                         input logic ac, input logic az);
        reset         = rst;
        bus_if.enable = en;
        bus_if.instr  = instr;
        bus_if.alu_c  = ac;
        bus_if.alu_z  = az;
    endtask

    initial begin
        int fetches;
        int execs;
        logic [15:0] exp_w;

        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
`ifdef NIBBLE_SEQ_STEP_EN
        step = 1'b1;
`endif

        add(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_NONE, PA);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, S_OPR | S_ACC, ADD);
        fet(1'b1, 1'b1, 1'b0);
        ex (1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, S_PCL, PA);
        fet(1'b1, 1'b1, 1'b0);
        ex (1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, S_NONE, PA);
        fet(1'b1, 1'b1, 1'b0);
        ex (1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 1'b0, S_OPR, SUB);
        fet(1'b1, 1'b0, 1'b1);
        ex (1'b1, 4'h8, 1'b1, 1'b0, 1'b0, 1'b1, S_PCL, PA);
        fet(1'b1, 1'b0, 1'b1);
        ex (1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1, S_NONE, PA);
        fet(1'b1, 1'b0, 1'b1);
        ex (1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, S_OPR | S_ACC, PB);
        fet(1'b1, 1'b0, 1'b1);
        ex (1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, S_IN | S_ACC, PB);
        fet(1'b1, 1'b0, 1'b1);
        ex (1'b1, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, S_RAM | S_ACC, PB);
        fet(1'b1, 1'b0, 1'b1);
        ex (1'b1, 4'hD, 1'b1, 1'b0, 1'b0, 1'b1, S_ALU | S_OUTW, PA);
        fet(1'b1, 1'b0, 1'b1);
        ex (1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1, S_OPR | S_ACC, NAND);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, S_RAM | S_ACC, NAND);
        fet(1'b1, 1'b0, 1'b1);
        ex (1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, S_RAM | S_ACC, ADD);
        fet(1'b1, 1'b1, 1'b1);
        ex (1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, S_RAM, SUB);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, S_NONE, PA);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, S_PCL, PA);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, S_PCL, PA);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0, S_NONE, PA);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, S_PCL, PA);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b0, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0, S_ALU | S_RAMW, PA);
        for (int k = 0; k < 5; k++) fet(1'b0, 1'b0, 1'b0);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, S_OPR | S_ACC, ADD);
        fet(1'b1, 1'b1, 1'b1);
        add(1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, S_NONE, PA);
        fet(1'b1, 1'b0, 1'b0);
        ex (1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0, S_OPR | S_ACC, PB);
        fet(1'b0, 1'b0, 1'b0);

        @(posedge clock);
        @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            drive(vecs[i].rst, vecs[i].en, vecs[i].instr, vecs[i].ac, vecs[i].az);
            sb_q.push_back(vecs[i].exp);
            @(negedge clock);
            exp_w = sb_q.pop_front();
            check($sformatf("vec%0d_op%h", i, vecs[i].instr), act_word(), exp_w);
            @(posedge clock);
        end

        // Reset pulse then free run: phase must alternate starting in FETCH.
        #1;
        drive(1'b1, 1'b1, 4'hC, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        drive(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check($sformatf("alt%0d_phase", i), {15'd0, bus_if.phase}, {15'd0, 1'(i % 2)});
            check($sformatf("alt%0d_fetch", i), {14'd0, bus_if.fetch_en, bus_if.pc_inc},
                  (i % 2 == 0) ? 16'd3 : 16'd0);
            @(posedge clock);
        end

`ifdef NIBBLE_SEQ_STEP_EN
        // Single step pulse among ten cycles yields exactly one fetch and one EXEC.
        #1;
        drive(1'b1, 1'b1, 4'h4, 1'b0, 1'b0);
        step = 1'b0;
        @(posedge clock);
        fetches = 0;
        execs   = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            reset = 1'b0;
            step  = (i == 3) ? 1'b1 : 1'b0;
            @(negedge clock);
            if (bus_if.fetch_en) fetches++;
            if (bus_if.phase) execs++;
            @(posedge clock);
        end
        check("step_fetches", 16'(fetches), 16'd1);
        check("step_execs", 16'(execs), 16'd1);
        step = 1'b1;
`else
        fetches = 0;
        execs   = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
